// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_pc_next.sv
// Next-PC selection (sequential / redirect / hold) and redirect alignment check.
// Purely combinational; decides which kind of update the fetch stage performs this cycle.
module pc_next
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
) (
  input  fetch_state_t             state,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic [ADDRESS_WIDTH-1:0] next_pc,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4,
  output logic                     capture,
  output logic                     flush,
  output logic                     trap
);

  logic misaligned;

  // Modulo 2^ADDRESS_WIDTH: the carry out of the top bit is simply dropped.
  assign pc_plus4   = pc + ADDRESS_WIDTH'(4);
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  always_comb begin
    next_pc = pc;
    capture = 1'b0;
    flush   = 1'b0;
    trap    = 1'b0;
    if (state != TRAP) begin
      if (redirect) begin
        if (misaligned) begin
          trap = 1'b1;
        end else begin
          flush   = 1'b1;
          next_pc = redirect_pc;
        end
      end else if (state == RUN && !stall) begin
        capture = 1'b1;
        next_pc = pc_plus4;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/TRAP control and the IF/ID pipeline register.
// The memory read is combinational on pc_o, so a fetched word lands in IF/ID one edge later.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  input  logic [DATA_WIDTH-1:0]    instr_i,
  output logic                     ifid_valid_o,
  output logic [ADDRESS_WIDTH-1:0] ifid_pc_o,
  output logic [ADDRESS_WIDTH-1:0] ifid_pc4_o,
  output logic [DATA_WIDTH-1:0]    ifid_instr_o,
  output logic                     fault_o,
  output logic [ADDRESS_WIDTH-1:0] fault_pc_o
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

  fetch_state_t             state;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] next_pc;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     capture;
  logic                     flush;
  logic                     trap;

  pc_next #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_pc_next (
    .state      (state),
    .pc         (pc),
    .stall      (stall_i),
    .redirect   (redirect_i),
    .redirect_pc(redirect_pc_i),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .capture    (capture),
    .flush      (flush),
    .trap       (trap)
  );

  assign pc_o = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      ifid_valid_o <= 1'b0;
      ifid_pc_o    <= '0;
      ifid_pc4_o   <= '0;
      ifid_instr_o <= NOP;
      fault_o      <= 1'b0;
      fault_pc_o   <= '0;
    end else begin
      pc <= next_pc;
      case (state)
        BOOT, RUN: begin
          if (trap) begin
            // A misaligned target wins over the BOOT->RUN step; the stage parks until reset.
            state        <= TRAP;
            fault_o      <= 1'b1;
            fault_pc_o   <= redirect_pc_i;
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= NOP;
          end else begin
            state <= RUN;
            if (flush) begin
              ifid_valid_o <= 1'b0;
              ifid_instr_o <= NOP;
            end else if (capture) begin
              ifid_valid_o <= 1'b1;
              ifid_pc_o    <= pc;
              ifid_pc4_o   <= pc_plus4;
              ifid_instr_o <= instr_i;
            end
          end
        end
        TRAP: begin
          ifid_valid_o <= 1'b0;
        end
        default: begin
          state <= TRAP;
        end
      endcase
    end
  end

endmodule
